apb4_arbiter2: RTL and testbench
================================

# apb4_arbiter2

Two-requester APB4 master arbiter. It shares one APB4 bus, driving a single slave such as the APB4 memory, between two simple request/done ports. Arbitration is round-robin, and the block owns the bus FSM: it generates PSEL/PENABLE, holds the address and data phases stable, and returns PRDATA/PSLVERR to the winning requester.

## Interface
Clocking is fixed: one clock, PCLK; reset PRESETn is asynchronous and active-low.

Parameters:
- AW, 32, address width
- DW, 32, data width
- DS, DW/8, strobe width
- TMO, 16, ACCESS-phase timeout in cycles (used only with APB4_ARB_TIMEOUT_EN)

Ports (suffix x = 0 or 1, one set per requester):
- PCLK  in  1  clock
- PRESETn  in  1  async active-low reset
- REQx  in  1  request; held high until DONEx
- ADDRx  in  AW  transfer address
- WRITEx  in  1  1 = write
- WDATAx  in  DW  write data
- STRBx  in  DS  write strobes
- PROTx  in  3  protection
- DONEx  out  1  one-cycle completion pulse
- RDATAx  out  DW  read data, valid while DONEx = 1
- ERRx  out  1  slave error, valid while DONEx = 1
- PSEL, PENABLE, PWRITE  out  1  APB4 controls
- PADDR  out  AW  APB4 address
- PWDATA  out  DW  APB4 write data
- PSTRB  out  DS  APB4 strobes
- PPROT  out  3  APB4 protection
- PRDATA  in  DW  APB4 read data
- PREADY, PSLVERR  in  1  APB4 ready and error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE.** If any unmasked REQx is high, grant it and go to SETUP. The requester whose DONEx is high in the current cycle is masked.
- **Round-robin.** Register LAST holds the previous grantee; its reset value is 1, so requester 0 wins first. When both request, grant the requester other than LAST. A single requester always wins. LAST updates at grant.
- **Latch at grant.** On grant, the winner's ADDR, WRITE, WDATA, STRB and PROT are latched into the P* output registers. Outputs stay stable until the next grant.
- **Strobes.** PSTRB is forced to 0 for reads. PWDATA is don't-care for reads but still latched.
- **SETUP.** PSEL=1, PENABLE=0; go to ACCESS unconditionally.
- **ACCESS.** PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS.
  - PREADY=1: capture PRDATA into RDATAg and PSLVERR into ERRg, then go to IDLE with PSEL=PENABLE=0.
- **Completion.** DONEg pulses high for exactly one cycle, in the cycle after PREADY is sampled.
- **RDATA.** RDATAx holds its last value between completions. For writes it is loaded with PRDATA anyway; the requester ignores it.
- **Mid-transfer REQ drop.** A requester dropping REQx during SETUP/ACCESS is a protocol violation. The transfer completes regardless.
- **Reset.** Asserting PRESETn mid-transfer aborts the transfer immediately. No DONE is issued and all outputs return to their reset values.

## Timing
- Reset values: PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, PSTRB, PPROT = 0; DONE0/1 = 0; ERR0/1 = 0; RDATA0/1 = 0; state IDLE; LAST = 1.
- Zero-wait transfer:
  - REQx sampled high at edge 0.
  - SETUP in cycle 1.
  - ACCESS in cycle 2, with PREADY=1.
  - DONEx in cycle 3, with the FSM back in IDLE.
  - Total: 3 cycles from request to DONE; each wait state adds 1.
- Back-to-back transfers:
  - There is one IDLE cycle minimum between transfers. The DONE cycle serves as that IDLE cycle.
  - A pending other requester is granted in the DONE cycle, so its SETUP starts the cycle after DONE.
  - Bus pattern for alternating requesters: SETUP, ACCESS, IDLE, SETUP, …
- One requester holding REQx continuously is masked during its own DONE cycle, so its next request is granted one cycle later.

## Configuration
- Macro: APB4_ARB_TIMEOUT_EN.
- **Defined:**
  - A counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TMO while PREADY is still 0, the transfer is abandoned: PSEL and PENABLE drop and the FSM goes to IDLE.
  - DONEg then pulses with ERRg=1 and RDATAg=all-ones.
  - PREADY=1 in the same cycle as the limit takes precedence, giving normal completion.
- **Undefined:** there is no counter, and ACCESS waits indefinitely for PREADY.

## Test plan
- **Reset:** after reset, write 0xA5A5_1234 to 0x10 from requester 0 with STRB=0xF, zero-wait slave → PSEL in cycle 1, PENABLE in cycle 2, DONE0 in cycle 3 with ERR0=0; a read of 0x10 returns RDATA0 = 0xA5A5_1234.
- **Simultaneous requests:** REQ0 and REQ1 rise in the same cycle → grant order 0, 1. Repeating with both held continuously → grants alternate 0, 1, 0, 1 and each DONE has a 3-cycle spacing.
- **Wait states:** slave holds PREADY=0 for 3 ACCESS cycles on a read → PADDR/PSEL/PENABLE stay stable; DONE asserts 1 cycle after PREADY rises; RDATA equals PRDATA at that edge.
- **Read strobes:** read with STRB0=0xF → PSTRB=0 on the bus. Separately, PSLVERR=1 on a write → ERRx=1 for the DONE cycle only.
- **Reset mid-ACCESS:** PRESETn pulsed low during ACCESS → PSEL, PENABLE and DONE go to 0 asynchronously; after release, the first grant goes to requester 0.
- **Timeout (APB4_ARB_TIMEOUT_EN, TMO=16):** PREADY stuck low → PSEL drops after 16 ACCESS cycles; DONE shows ERR=1 and RDATA=0xFFFF_FFFF; the next request proceeds normally.

Source files
------------

// File: rtl/apb4_arbiter2_if.sv
// Signal bundle for apb4_arbiter2: two request/done ports plus the shared APB4 bus.
// The master modport is the arbiter's view; slave is the view of the surrounding system.
interface apb4_arbiter2_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned DS = DW / 8
);
  // Requester side, index 0/1 selects the requester
  logic [1:0]               req;
  logic [1:0][AW-1:0]       addr;
  logic [1:0]               write;
  logic [1:0][DW-1:0]       wdata;
  logic [1:0][DS-1:0]       strb;
  logic [1:0][2:0]          prot;
  logic [1:0]               done;
  logic [1:0][DW-1:0]       rdata;
  logic [1:0]               err;

  // APB4 side
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [AW-1:0]            paddr;
  logic [DW-1:0]            pwdata;
  logic [DS-1:0]            pstrb;
  logic [2:0]               pprot;
  logic [DW-1:0]            prdata;
  logic                     pready;
  logic                     pslverr;

  modport master (
    input  req, addr, write, wdata, strb, prot,
    output done, rdata, err,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req, addr, write, wdata, strb, prot,
    input  done, rdata, err,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_arbiter2.sv
// Two-requester round-robin APB4 master arbiter owning the IDLE/SETUP/ACCESS bus FSM.
// Optional ACCESS-phase timeout enabled by defining APB4_ARB_TIMEOUT_EN.
module apb4_arbiter2 #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned DS  = DW / 8,
  parameter int unsigned TMO = 16
) (
  input  logic            pclk_i,
  input  logic            presetn_i,
  apb4_arbiter2_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               gnt_q, gnt_d;
  logic               pwrite_q, pwrite_d;
  logic [AW-1:0]      paddr_q, paddr_d;
  logic [DW-1:0]      pwdata_q, pwdata_d;
  logic [DS-1:0]      pstrb_q, pstrb_d;
  logic [2:0]         pprot_q, pprot_d;
  logic [1:0]         done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;

  logic [1:0]         cand;
  logic               win;
  logic               tmo_hit;

  // A requester is masked in its own DONE cycle so it cannot re-win immediately
  assign cand = bus_io.req & ~done_q;
  assign win  = (cand == 2'b11) ? ~last_q : cand[1];

`ifdef APB4_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the TMO-th stalled ACCESS cycle; PREADY in that cycle still wins
  assign tmo_hit = (state_q == StAccess) && !bus_io.pready && (cnt_q == CW'(TMO - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if ((state_q == StAccess) && !bus_io.pready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^TMO;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    done_d   = '0;
    err_d    = '0;
    rdata_d  = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (|cand) begin
          state_d  = StSetup;
          gnt_d    = win;
          last_d   = win;
          pwrite_d = bus_io.write[win];
          paddr_d  = bus_io.addr[win];
          pwdata_d = bus_io.wdata[win];
          pstrb_d  = bus_io.write[win] ? bus_io.strb[win] : '0;
          pprot_d  = bus_io.prot[win];
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (bus_io.pready) begin
          state_d        = StIdle;
          done_d[gnt_q]  = 1'b1;
          err_d[gnt_q]   = bus_io.pslverr;
          rdata_d[gnt_q] = bus_io.prdata;
        end else if (tmo_hit) begin
          state_d        = StIdle;
          done_d[gnt_q]  = 1'b1;
          err_d[gnt_q]   = 1'b1;
          rdata_d[gnt_q] = '1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus_io.psel    = (state_q != StIdle);
  assign bus_io.penable = (state_q == StAccess);
  assign bus_io.pwrite  = pwrite_q;
  assign bus_io.paddr   = paddr_q;
  assign bus_io.pwdata  = pwdata_q;
  assign bus_io.pstrb   = pstrb_q;
  assign bus_io.pprot   = pprot_q;
  assign bus_io.done    = done_q;
  assign bus_io.err     = err_q;
  assign bus_io.rdata   = rdata_q;

endmodule

// File: tb/tb_apb4_arbiter2.sv
// Self-checking bench for apb4_arbiter2: memory slave, transaction-level timing/data model.
// Timeout scenarios run only when APB4_ARB_TIMEOUT_EN is defined.
module tb_apb4_arbiter2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned DS  = 4;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb4_arbiter2_if #(.AW(AW), .DW(DW), .DS(DS)) bus ();

  apb4_arbiter2 #(.AW(AW), .DW(DW), .DS(DS), .TMO(TMO)) dut (
    .pclk_i   (clk),
    .presetn_i(rst_n),
    .bus_io   (bus)
  );

  // Slave: 16-word memory, region (paddr[5]) selects wait states and error response
  logic [DW-1:0] mem [16];
  logic          mem_clr;
  int unsigned   wait_cfg [2];
  logic          err_cfg [2];
  int unsigned   acc_cnt;

  always_ff @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
      for (int b = 0; b < DS; b++)
        if (bus.pstrb[b]) mem[bus.paddr[5:2]][8*b +: 8] <= bus.pwdata[8*b +: 8];
    end
    if (bus.psel && bus.penable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    bus.prdata  = mem[bus.paddr[5:2]];
    bus.pready  = bus.psel && bus.penable && (acc_cnt >= wait_cfg[bus.paddr[5]]);
    bus.pslverr = bus.pready && err_cfg[bus.paddr[5]];
  end

  // Reference state
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_rd [2];
  int            lastm;
  logic [AW-1:0] tx_addr [2];
  logic          tx_wr [2];
  logic [DW-1:0] tx_wd [2];
  logic [DS-1:0] tx_st [2];
  logic [2:0]    tx_pr [2];

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tx(input int r, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DS-1:0] s, input logic [2:0] p);
    tx_addr[r] = a; tx_wr[r] = wr; tx_wd[r] = d; tx_st[r] = s; tx_pr[r] = p;
    bus.addr[r] = a; bus.write[r] = wr; bus.wdata[r] = d; bus.strb[r] = s; bus.prot[r] = p;
  endtask

  // Requester r performs c[r] back-to-back transfers holding REQ; model predicts every cycle.
  task automatic run(input int c0, input int c1);
    int   rem [2];
    int   target [2];
    int   tr_r [$];
    int   tr_s [$];
    int   tr_d [$];
    logic tr_to [$];
    int   g, msk, w, dur, cur, last_done;
    logic to, ed, ee, es, en;
    logic [1:0] cand;
    logic [3:0] wd;
    rem[0] = c0; rem[1] = c1; target[0] = c0; target[1] = c1;
    g = 0; msk = -1;
    while (rem[0] + rem[1] > 0) begin
      cand = {(rem[1] > 0) && (msk != 1), (rem[0] > 0) && (msk != 0)};
      if (cand == 2'b00) begin
        g++; msk = -1;
        continue;
      end
      w = (cand == 2'b11) ? 1 - lastm : (cand[1] ? 1 : 0);
      lastm = w;
`ifdef APB4_ARB_TIMEOUT_EN
      to = (wait_cfg[w] >= TMO);
`else
      to = 1'b0;
`endif
      dur = to ? TMO : int'(wait_cfg[w]) + 1;
      tr_r.push_back(w); tr_s.push_back(g + 1); tr_d.push_back(g + 2 + dur); tr_to.push_back(to);
      rem[w]--;
      g = g + 2 + dur;
      msk = w;
    end
    last_done = tr_d[tr_d.size() - 1];
    bus.req = {c1 > 0, c0 > 0};
    for (int k = 1; k <= last_done + 1; k++) begin
      step();
      es = 1'b0; en = 1'b0; cur = -1;
      foreach (tr_s[i]) if (k >= tr_s[i] && k < tr_d[i]) begin
        es = 1'b1; en = (k > tr_s[i]); cur = tr_r[i];
      end
      chk("psel", bus.psel, es);
      chk("penable", bus.penable, en);
      if (cur >= 0) begin
        chk("paddr", bus.paddr, tx_addr[cur]);
        chk("pwrite", bus.pwrite, tx_wr[cur]);
        chk("pwdata", bus.pwdata, tx_wd[cur]);
        chk("pstrb", bus.pstrb, tx_wr[cur] ? tx_st[cur] : '0);
        chk("pprot", bus.pprot, tx_pr[cur]);
      end
      for (int r = 0; r < 2; r++) begin
        ed = 1'b0; ee = 1'b0;
        foreach (tr_d[i]) if (tr_d[i] == k && tr_r[i] == r) begin
          ed = 1'b1;
          if (tr_to[i]) begin
            ee = 1'b1; exp_rd[r] = '1;
          end else begin
            ee = err_cfg[r];
            wd = tx_addr[r][5:2];
            exp_rd[r] = ref_mem[wd];
            if (tx_wr[r])
              for (int b = 0; b < DS; b++)
                if (tx_st[r][b]) ref_mem[wd][8*b +: 8] = tx_wd[r][8*b +: 8];
          end
          target[r]--;
          if (target[r] == 0) bus.req[r] = 1'b0;
        end
        chk($sformatf("done%0d@%0d", r, k), bus.done[r], ed);
        chk($sformatf("err%0d@%0d", r, k), bus.err[r], ee);
        chk($sformatf("rdata%0d@%0d", r, k), bus.rdata[r], exp_rd[r]);
      end
    end
  endtask

  task automatic rand_tx(input int r);
    logic [AW-1:0] a;
    a = $urandom();
    a[5] = r[0];
    a[1:0] = 2'b00;
    set_tx(r, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    bus.req = 2'b00;
    set_tx(0, 1'b0, '0, '0, '0, '0);
    set_tx(1, 1'b0, 32'h20, '0, '0, '0);
    wait_cfg[0] = 0; wait_cfg[1] = 0;
    err_cfg[0] = 1'b0; err_cfg[1] = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    lastm = 1;
    mem_clr = 1'b1;
    step();
    step();
    mem_clr = 1'b0;

    // Reset values
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_pwrite", bus.pwrite, 1'b0);
    chk("rst_paddr", bus.paddr, '0);
    chk("rst_pwdata", bus.pwdata, '0);
    chk("rst_pstrb", bus.pstrb, '0);
    chk("rst_pprot", bus.pprot, '0);
    chk("rst_done", bus.done, '0);
    chk("rst_err", bus.err, '0);
    chk("rst_rdata0", bus.rdata[0], '0);
    chk("rst_rdata1", bus.rdata[1], '0);
    rst_n = 1'b1;
    step();

    // Write then read back from requester 0, zero-wait
    set_tx(0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 3'b010);
    run(1, 0);
    set_tx(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
    run(1, 0);
    chk("readback", bus.rdata[0], 32'hA5A5_1234);

    // Wait states on a read
    wait_cfg[0] = 3;
    run(1, 0);
    wait_cfg[0] = 0;

    // Slave error on a write from requester 1
    err_cfg[1] = 1'b1;
    set_tx(1, 1'b1, 32'h24, 32'h1357_9BDF, 4'h5, 3'b001);
    run(0, 1);
    err_cfg[1] = 1'b0;

    // Single requester holding REQ across two transfers
    run(2, 0);

    // Reset during ACCESS
    wait_cfg[0] = 5;
    set_tx(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
    bus.req = 2'b01;
    step(); step(); step();
    chk("mid_penable", bus.penable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_psel", bus.psel, 1'b0);
    chk("arst_penable", bus.penable, 1'b0);
    chk("arst_done", bus.done, '0);
    chk("arst_rdata0", bus.rdata[0], '0);
    chk("arst_paddr", bus.paddr, '0);
    bus.req = 2'b00;
    step();
    rst_n = 1'b1;
    lastm = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    wait_cfg[0] = 0;
    step();

    // Simultaneous requests after reset, then both held continuously
    set_tx(1, 1'b0, 32'h30, 32'h0, 4'hF, 3'b100);
    run(1, 1);
    run(3, 3);

`ifdef APB4_ARB_TIMEOUT_EN
    wait_cfg[0] = TMO - 1;
    run(1, 0);
    wait_cfg[0] = 1000;
    run(1, 0);
    wait_cfg[0] = 0;
    run(1, 0);
`endif

    // Randomized rounds
    for (int it = 0; it < 40; it++) begin
      rand_tx(0);
      rand_tx(1);
      wait_cfg[0] = $urandom_range(0, 3);
      wait_cfg[1] = $urandom_range(0, 3);
      err_cfg[0] = ($urandom_range(0, 3) == 0);
      err_cfg[1] = ($urandom_range(0, 3) == 0);
      c0 = $urandom_range(0, 2);
      c1 = $urandom_range(0, 2);
      if (c0 + c1 == 0) c0 = 1;
      run(c0, c1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
